// File: rtl/dp_ram_port_arbiter.sv
// dp_ram_port_arbiter: round-robin sharing of dual-port RAM port B among NUM_REQ OBI-style masters.
// Define DP_RAM_ARB_RANGE_CHECK_EN to turn out-of-range addresses into error responses.
module dp_ram_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    input  logic [NUM_REQ-1:0][31:0]     addr_i,
    input  logic [NUM_REQ-1:0]           we_i,
    input  logic [NUM_REQ-1:0][3:0]      be_i,
    input  logic [NUM_REQ-1:0][31:0]     wdata_i,
    output logic [NUM_REQ-1:0]           rvalid_o,
    output logic [NUM_REQ-1:0][31:0]     rdata_o,
    output logic [NUM_REQ-1:0]           err_o,
    output logic                         ram_en_o,
    output logic [ADDR_WIDTH-1:0]        ram_addr_o,
    output logic [31:0]                  ram_wdata_o,
    output logic                         ram_we_o,
    output logic [3:0]                   ram_be_o,
    input  logic [31:0]                  ram_rdata_i
);

    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("dp_ram_port_arbiter: NUM_REQ must be 2..4");
    end

    logic [IW-1:0] prio_q;
    logic [IW-1:0] prio_nxt;
    logic [IW-1:0] win_idx;
    logic          any_gnt;
    logic          range_err;
    int            cand;

    logic          resp_valid_q;
    logic [IW-1:0] resp_id_q;
    logic          resp_we_q;
    logic          resp_err_q;

    // Stage p0: rotate the scan start to prio_q; the first requester found wins.
    always_comb begin
        any_gnt = 1'b0;
        win_idx = '0;
        cand    = 0;
        if (!rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = int'(prio_q) + i;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!any_gnt && req_i[IW'(cand)]) begin
                    any_gnt = 1'b1;
                    win_idx = IW'(cand);
                end
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (any_gnt) begin
            gnt_o[win_idx] = 1'b1;
        end
    end

    assign prio_nxt = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef DP_RAM_ARB_RANGE_CHECK_EN
    assign range_err = any_gnt && (addr_i[win_idx][31:ADDR_WIDTH] != '0);
`else
    // Upper address bits alias onto the RAM; they are deliberately ignored.
    logic unused_addr_upper;
    assign unused_addr_upper = ^addr_i;
    assign range_err         = 1'b0;
`endif

    assign ram_en_o    = any_gnt && !range_err;
    assign ram_we_o    = ram_en_o && we_i[win_idx];
    assign ram_addr_o  = addr_i[win_idx][ADDR_WIDTH-1:0];
    assign ram_wdata_o = wdata_i[win_idx];
    assign ram_be_o    = be_i[win_idx];

    // Stage p1: remember who was granted so the RAM's 1-cycle read data can be routed back.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_we_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= any_gnt;
            if (any_gnt) begin
                prio_q     <= prio_nxt;
                resp_id_q  <= win_idx;
                resp_we_q  <= we_i[win_idx];
                resp_err_q <= range_err;
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        err_o    = '0;
        if (resp_valid_q) begin
            rvalid_o[resp_id_q] = 1'b1;
            err_o[resp_id_q]    = resp_err_q;
            rdata_o[resp_id_q]  = (resp_we_q || resp_err_q) ? 32'd0 : ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Bench for dp_ram_port_arbiter: directed table/sequences plus randomized traffic against a reference model.
module tb_dp_ram_port_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [1:0][31:0]  addr;
    logic [1:0]        we;
    logic [1:0][3:0]   be;
    logic [1:0][31:0]  wdata;
    logic [1:0]        rvalid;
    logic [1:0][31:0]  rdata;
    logic [1:0]        err;
    logic              ram_en;
    logic [17:0]       ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_rdata;

    logic              bd_we;
    logic [15:0]       bd_idx;
    logic [31:0]       bd_val;
    logic [31:0]       ram_mem [65536];
    logic [31:0]       ref_mem [16];
    logic [1:0]        last_gnt;
    bit                inv_on = 1'b0;
    int                checks = 0;
    int                failures = 0;

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
        logic [1:0] rv;
    } vec_t;
    vec_t tbl [13];

    always #5 clk = ~clk;

    dp_ram_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(18)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we),
        .ram_be_o(ram_be), .ram_rdata_i(ram_rdata)
    );

    // Behavioural RAM with 1-cycle read latency and a backdoor for preloading.
    always @(posedge clk) begin
        if (bd_we) begin
            ram_mem[bd_idx] <= bd_val;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) ram_mem[ram_addr[17:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= ram_mem[ram_addr[17:2]];
            end
        end
    end

    always @(posedge clk) last_gnt <= gnt;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        if (inv_on) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("rvalid_eq_past_gnt", 32'(rvalid), 32'(last_gnt));
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    task automatic bd_write(input int idx, input logic [31:0] val);
        bd_we  = 1'b1;
        bd_idx = 16'(idx);
        bd_val = val;
        tick();
        bd_we  = 1'b0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef DP_RAM_ARB_RANGE_CHECK_EN
        return a[31:18] != 14'd0;
`else
        return (a[31] & 1'b0) != 1'b0;
`endif
    endfunction

    task automatic run_random(input int n);
        int          prio;
        bit          pend;
        int          pid;
        bit          perr;
        logic [31:0] pdata;
        int          k;
        int          j;
        bit          e;
        logic [1:0]  exp_gnt;
        logic [1:0]  exp_rv;
        logic [1:0]  exp_err;
        logic [1:0]  held;
        logic [13:0] up;
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            bd_write(i, 32'd0);
            ref_mem[i] = 32'd0;
        end
        prio = 0;
        pend = 1'b0;
        pid = 0;
        perr = 1'b0;
        pdata = 32'd0;
        held = 2'b00;
        for (int c = 0; c < n; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int m = 0; m < 2; m++) begin
                if (!held[m]) begin
                    up       = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(1, 16383)) : 14'd0;
                    req[m]   = ($urandom_range(0, 3) != 0);
                    we[m]    = $urandom_range(0, 1) == 1;
                    be[m]    = 4'($urandom_range(0, 15));
                    wdata[m] = $urandom;
                    addr[m]  = {up, 12'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                end
            end
            at_neg();
            exp_rv  = 2'b00;
            exp_err = 2'b00;
            if (pend) begin
                exp_rv[pid]  = 1'b1;
                exp_err[pid] = perr;
            end
            chk("rnd_rvalid", 32'(rvalid), 32'(exp_rv));
            chk("rnd_err", 32'(err), 32'(exp_err));
            chk("rnd_rdata0", rdata[0], (pend && pid == 0) ? pdata : 32'd0);
            chk("rnd_rdata1", rdata[1], (pend && pid == 1) ? pdata : 32'd0);
            k = -1;
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    j = (prio + i) % 2;
                    if (k < 0 && req[j]) k = j;
                end
            end
            exp_gnt = (k >= 0) ? 2'(1 << k) : 2'b00;
            chk("rnd_gnt", 32'(gnt), 32'(exp_gnt));
            if (k >= 0) begin
                e = out_of_range(addr[k]);
                chk("rnd_ram_en", 32'(ram_en), 32'(!e));
                if (!e) begin
                    chk("rnd_ram_addr", 32'(ram_addr), 32'(addr[k][17:0]));
                    chk("rnd_ram_we", 32'(ram_we), 32'(we[k]));
                    if (we[k]) begin
                        chk("rnd_ram_wdata", ram_wdata, wdata[k]);
                        chk("rnd_ram_be", 32'(ram_be), 32'(be[k]));
                    end
                end else begin
                    chk("rnd_ram_we_err", 32'(ram_we), 32'd0);
                end
                pend  = 1'b1;
                pid   = k;
                perr  = e;
                pdata = (we[k] || e) ? 32'd0 : ref_mem[addr[k][5:2]];
                if (we[k] && !e) ref_mem[addr[k][5:2]] = merge(ref_mem[addr[k][5:2]], wdata[k], be[k]);
                prio = (k + 1) % 2;
            end else begin
                chk("rnd_ram_en_idle", 32'(ram_en), 32'd0);
                pend = 1'b0;
                if (rst) prio = 0;
            end
            held = req & ~exp_gnt & ~{2{rst}};
            tick();
        end
        rst = 1'b0;
        req = 2'b00;
    endtask

    initial begin
        tbl[0]  = '{2'b11, 2'b01, 2'b00};
        tbl[1]  = '{2'b11, 2'b10, 2'b01};
        tbl[2]  = '{2'b11, 2'b01, 2'b10};
        tbl[3]  = '{2'b11, 2'b10, 2'b01};
        tbl[4]  = '{2'b11, 2'b01, 2'b10};
        tbl[5]  = '{2'b11, 2'b10, 2'b01};
        tbl[6]  = '{2'b10, 2'b10, 2'b10};
        tbl[7]  = '{2'b01, 2'b01, 2'b10};
        tbl[8]  = '{2'b00, 2'b00, 2'b01};
        tbl[9]  = '{2'b11, 2'b10, 2'b00};
        tbl[10] = '{2'b01, 2'b01, 2'b10};
        tbl[11] = '{2'b01, 2'b01, 2'b01};
        tbl[12] = '{2'b00, 2'b00, 2'b01};

        rst = 1'b1; req = 2'b11; we = 2'b00; be = '0; wdata = '0;
        addr[0] = 32'h10; addr[1] = 32'h10;
        bd_we = 1'b0; bd_idx = '0; bd_val = '0;

        // Reset state and a single read.
        tick();
        at_neg();
        chk("gnt_in_reset", 32'(gnt), 32'd0);
        chk("ram_en_in_reset", 32'(ram_en), 32'd0);
        tick();
        rst = 1'b0; req = 2'b00;
        at_neg();
        chk("rvalid_after_reset", 32'(rvalid), 32'd0);
        chk("err_after_reset", 32'(err), 32'd0);
        inv_on = 1'b1;
        bd_write(4, 32'hDEADBEEF);
        req = 2'b01;
        at_neg();
        chk("t1_gnt", 32'(gnt), 32'b01);
        chk("t1_ram_en", 32'(ram_en), 32'd1);
        chk("t1_ram_addr", 32'(ram_addr), 32'h10);
        chk("t1_ram_we", 32'(ram_we), 32'd0);
        tick();
        req = 2'b00;
        at_neg();
        chk("t1_rvalid", 32'(rvalid), 32'b01);
        chk("t1_rdata0", rdata[0], 32'hDEADBEEF);
        chk("t1_rdata1", rdata[1], 32'd0);
        tick();

        // Round-robin vector table.
        reset_dut();
        for (int i = 0; i < 13; i++) begin
            req = tbl[i].req;
            at_neg();
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_rdata0", i), rdata[0], tbl[i].rv[0] ? 32'hDEADBEEF : 32'd0);
            chk($sformatf("tbl%0d_rdata1", i), rdata[1], tbl[i].rv[1] ? 32'hDEADBEEF : 32'd0);
            tick();
        end

        // Partial write by m1, read back by m0.
        bd_write(8, 32'd0);
        req = 2'b10; we = 2'b10; addr[1] = 32'h20; wdata[1] = 32'h11223344; be[1] = 4'b0101;
        at_neg();
        chk("t3_gnt1", 32'(gnt), 32'b10);
        chk("t3_ram_we", 32'(ram_we), 32'd1);
        chk("t3_ram_be", 32'(ram_be), 32'b0101);
        chk("t3_ram_wdata", ram_wdata, 32'h11223344);
        chk("t3_ram_addr", 32'(ram_addr), 32'h20);
        tick();
        req = 2'b01; we = 2'b00; addr[0] = 32'h20; be[0] = 4'hF;
        at_neg();
        chk("t3_wr_rvalid", 32'(rvalid), 32'b10);
        chk("t3_wr_rdata1", rdata[1], 32'd0);
        chk("t3_gnt0", 32'(gnt), 32'b01);
        tick();
        req = 2'b00;
        at_neg();
        chk("t3_rd_rvalid", 32'(rvalid), 32'b01);
        chk("t3_rd_rdata0", rdata[0], 32'h00220044);
        tick();

        // Reset pulse right after a grant to m0.
        reset_dut();
        req = 2'b11; addr[0] = 32'h10; addr[1] = 32'h10;
        at_neg();
        chk("t4_first_gnt", 32'(gnt), 32'b01);
        tick();
        rst = 1'b1;
        at_neg();
        chk("t4_gnt_in_reset", 32'(gnt), 32'd0);
        chk("t4_rvalid_in_reset", 32'(rvalid), 32'b01);
        tick();
        rst = 1'b0;
        at_neg();
        chk("t4_no_rvalid", 32'(rvalid), 32'd0);
        chk("t4_gnt_after_reset", 32'(gnt), 32'b01);
        tick();
        req = 2'b00;

        // Write above the RAM size.
        bd_write(0, 32'hCAFEF00D);
        req = 2'b01; we = 2'b01; addr[0] = 32'h0004_0000; wdata[0] = 32'h55AA55AA; be[0] = 4'hF;
        at_neg();
        chk("t5_gnt", 32'(gnt), 32'b01);
`ifdef DP_RAM_ARB_RANGE_CHECK_EN
        chk("t5_ram_en", 32'(ram_en), 32'd0);
        chk("t5_ram_we", 32'(ram_we), 32'd0);
`else
        chk("t5_ram_en", 32'(ram_en), 32'd1);
        chk("t5_ram_addr", 32'(ram_addr), 32'd0);
`endif
        tick();
        req = 2'b00; we = 2'b00;
        at_neg();
        chk("t5_rvalid", 32'(rvalid), 32'b01);
        chk("t5_rdata0", rdata[0], 32'd0);
`ifdef DP_RAM_ARB_RANGE_CHECK_EN
        chk("t5_err", 32'(err), 32'b01);
        chk("t5_ram_unchanged", ram_mem[0], 32'hCAFEF00D);
`else
        chk("t5_err", 32'(err), 32'b00);
        chk("t5_ram_aliased", ram_mem[0], 32'h55AA55AA);
`endif
        tick();

        // Idle cycles, then a lone m1 request.
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t6_idle_gnt", 32'(gnt), 32'd0);
            chk("t6_idle_ram_en", 32'(ram_en), 32'd0);
            tick();
        end
        req = 2'b10; addr[1] = 32'h10;
        at_neg();
        chk("t6_gnt1", 32'(gnt), 32'b10);
        tick();
        req = 2'b00;
        at_neg();
        chk("t6_rvalid1", 32'(rvalid), 32'b10);
        chk("t6_rdata1", rdata[1], 32'hDEADBEEF);
        tick();

        run_random(800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
